// File: rtl/swc_driver_pkg.sv
// Shared definitions for the Swc instruction format and the command driver.
// The counter and the driver both take their opcode values from here.
package swc_driver_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_LD0  = 4'h1;
  localparam logic [3:0] OP_LD1  = 4'h2;
  localparam logic [3:0] OP_LD2  = 4'h3;
  localparam logic [3:0] OP_COU  = 4'h4;
  // 0x5/0x6 belong to the counter but are never issued by the driver
  localparam logic [3:0] OP_RSV5 = 4'h5;
  localparam logic [3:0] OP_RSV6 = 4'h6;
  localparam logic [3:0] OP_CCD  = 4'h7;
  localparam logic [3:0] OP_CCS  = 4'h8;

  typedef enum logic [1:0] {
    CMD_LOAD  = 2'd0,
    CMD_TIMER = 2'd1,
    CMD_STEP  = 2'd2,
    CMD_STOP  = 2'd3
  } cmd_op_e;

  typedef enum logic [3:0] {
    ST_RESET = 4'd0,
    ST_IDLE  = 4'd1,
    ST_LD0   = 4'd2,
    ST_LD1   = 4'd3,
    ST_LD2   = 4'd4,
    ST_START = 4'd5,
    ST_WAIT  = 4'd6,
    ST_STOP  = 4'd7,
    ST_DONE  = 4'd8,
    ST_ERROR = 4'd9
  } drv_state_e;

  typedef struct packed {
    logic [11:0] inst;
    logic        inst_en;
    logic        done;
    logic        aborted;
    logic        cmd_ready;
  } drv_out_t;

  function automatic logic [11:0] mk_inst(input logic [3:0] op, input logic [7:0] imm);
    return {op, imm};
  endfunction

endpackage

// File: rtl/swc_driver_if.sv
// Host-side command handshake into the Swc driver.
interface swc_driver_if;
  import swc_driver_pkg::*;

  logic        cmd_valid;
  cmd_op_e     cmd_op;
  logic [23:0] cmd_value;
  logic        cmd_ready;

  modport master (output cmd_valid, cmd_op, cmd_value, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_value, output cmd_ready);
endinterface

// File: rtl/swc_driver.sv
// Expands host commands into Swc instructions and reports completion.
// Outputs are registered from the decode of the state being entered.
module swc_driver
  import swc_driver_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  swc_driver_if.slave cmd,
  input  logic        abort,
  input  logic        swc_ready,
  output logic [11:0] inst,
  output logic        inst_en,
  output logic        done,
  output logic        aborted
);

  drv_state_e  state, state_nxt;
  cmd_op_e     op_q, op_cur;
  logic [23:0] value_q, value_cur;
  drv_out_t    out_q, out_nxt;
  logic        accept;

  assign accept = (state == ST_IDLE) && cmd.cmd_valid;

  // On the accept cycle the latches are not loaded yet, so decode from the bus
  assign op_cur    = accept ? cmd.cmd_op    : op_q;
  assign value_cur = accept ? cmd.cmd_value : value_q;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_RESET: state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (accept)
          state_nxt = (op_cur == CMD_LOAD || op_cur == CMD_TIMER) ? ST_LD0 : ST_STOP;
      end
      ST_LD0:   state_nxt = ST_LD1;
      ST_LD1:   state_nxt = ST_LD2;
      // A zero countdown skips CCD so the counter never wraps to 0xFFFFFF
      ST_LD2:   state_nxt = (op_q == CMD_TIMER && value_q != 24'd0) ? ST_START : ST_DONE;
      ST_START: state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (swc_ready)  state_nxt = ST_DONE;
        else if (abort) state_nxt = ST_STOP;
      end
      ST_STOP:  state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_ERROR;
    endcase
  end

  always_comb begin
    out_nxt = '0;
    case (state_nxt)
      ST_IDLE: out_nxt.cmd_ready = 1'b1;
      ST_LD0: begin
        out_nxt.inst_en = 1'b1;
        out_nxt.inst    = mk_inst(OP_LD0, value_cur[7:0]);
      end
      ST_LD1: begin
        out_nxt.inst_en = 1'b1;
        out_nxt.inst    = mk_inst(OP_LD1, value_cur[15:8]);
      end
      ST_LD2: begin
        out_nxt.inst_en = 1'b1;
        out_nxt.inst    = mk_inst(OP_LD2, value_cur[23:16]);
      end
      ST_START: begin
        out_nxt.inst_en = 1'b1;
        out_nxt.inst    = mk_inst(OP_CCD, 8'h00);
      end
      // Stop doubles as the single-instruction issue slot for STEP
      ST_STOP: begin
        out_nxt.inst_en = 1'b1;
        out_nxt.inst    = mk_inst((op_cur == CMD_STEP) ? OP_COU : OP_CCS, 8'h00);
      end
      ST_DONE: begin
        out_nxt.done    = 1'b1;
        out_nxt.aborted = (state == ST_STOP) && (op_q == CMD_TIMER);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state   <= ST_RESET;
      op_q    <= CMD_LOAD;
      value_q <= '0;
      out_q   <= '0;
    end else begin
      state <= state_nxt;
      out_q <= out_nxt;
      if (accept) begin
        op_q    <= cmd.cmd_op;
        value_q <= cmd.cmd_value;
      end
    end
  end

  assign cmd.cmd_ready = out_q.cmd_ready;
  assign inst          = out_q.inst;
  assign inst_en       = out_q.inst_en;
  assign done          = out_q.done;
  assign aborted       = out_q.aborted;

endmodule

// File: tb/tb_swc_driver.sv
// Directed and randomized checks of swc_driver against a transaction-level model,
// with a small behavioural counter standing in for the Swc.
module tb_swc_driver;
  import swc_driver_pkg::*;

  logic        clock = 1'b0;
  logic        reset;
  logic        abort;
  logic        swc_ready;
  logic [11:0] inst;
  logic        inst_en, done, aborted;

  swc_driver_if bus();

  swc_driver dut (
    .clock     (clock),
    .reset     (reset),
    .cmd       (bus.slave),
    .abort     (abort),
    .swc_ready (swc_ready),
    .inst      (inst),
    .inst_en   (inst_en),
    .done      (done),
    .aborted   (aborted)
  );

  always #5 clock = ~clock;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Counter stand-in; ready anticipates the last decrement to match the Swc latency
  logic [23:0] cnt;
  logic        down;
  always @(posedge clock) begin
    if (reset) begin
      cnt  <= '0;
      down <= 1'b0;
    end else if (inst_en) begin
      case (inst[11:8])
        4'h1: cnt[7:0]   <= inst[7:0];
        4'h2: cnt[15:8]  <= inst[7:0];
        4'h3: cnt[23:16] <= inst[7:0];
        4'h4: cnt <= cnt + 24'd1;
        4'h7: begin
          down <= 1'b1;
          if (cnt != 24'd0) cnt <= cnt - 24'd1;
        end
        4'h8: down <= 1'b0;
        default: ;
      endcase
    end else if (down && cnt != 24'd0) begin
      cnt <= cnt - 24'd1;
    end
  end
  assign swc_ready = down ? (cnt <= 24'd1) : (cnt == 24'd0);

  // Model: a queue of expected per-cycle outputs; a wait entry holds until ready/abort
  typedef struct packed {
    logic        wt;
    logic        en;
    logic [11:0] ins;
    logic        dn;
    logic        ab;
    logic        rdy;
  } exp_t;

  exp_t q[$];
  bit   model_on = 1'b0;

  function automatic exp_t mk(input bit wt, input bit en, input logic [11:0] ins,
                              input bit dn, input bit ab, input bit rdy);
    exp_t e;
    e.wt = wt; e.en = en; e.ins = ins; e.dn = dn; e.ab = ab; e.rdy = rdy;
    return e;
  endfunction

  always @(negedge clock) begin
    exp_t        e;
    logic [23:0] v;
    if (reset) begin
      model_on = 1'b1;
      q.delete();
      q.push_back(mk(0, 0, 12'h000, 0, 0, 0));
    end else if (model_on) begin
      e = (q.size() != 0) ? q[0] : mk(0, 0, 12'h000, 0, 0, 1);
      chk("m_inst_en",   inst_en,       e.en);
      chk("m_inst",      inst,          e.ins);
      chk("m_done",      done,          e.dn);
      chk("m_aborted",   aborted,       e.ab);
      chk("m_cmd_ready", bus.cmd_ready, e.rdy);
      if (q.size() != 0) begin
        if (!q[0].wt) void'(q.pop_front());
        else if (swc_ready) begin
          q.delete();
          q.push_back(mk(0, 0, 12'h000, 1, 0, 0));
        end else if (abort) begin
          q.delete();
          q.push_back(mk(0, 1, 12'h800, 0, 0, 0));
          q.push_back(mk(0, 0, 12'h000, 1, 1, 0));
        end
      end else if (bus.cmd_valid) begin
        v = bus.cmd_value;
        case (bus.cmd_op)
          CMD_LOAD, CMD_TIMER: begin
            q.push_back(mk(0, 1, {4'h1, v[7:0]},   0, 0, 0));
            q.push_back(mk(0, 1, {4'h2, v[15:8]},  0, 0, 0));
            q.push_back(mk(0, 1, {4'h3, v[23:16]}, 0, 0, 0));
            if (bus.cmd_op == CMD_LOAD || v == 24'd0) begin
              q.push_back(mk(0, 0, 12'h000, 1, 0, 0));
            end else begin
              q.push_back(mk(0, 1, 12'h700, 0, 0, 0));
              q.push_back(mk(1, 0, 12'h000, 0, 0, 0));
            end
          end
          CMD_STEP: begin
            q.push_back(mk(0, 1, 12'h400, 0, 0, 0));
            q.push_back(mk(0, 0, 12'h000, 1, 0, 0));
          end
          default: begin
            q.push_back(mk(0, 1, 12'h800, 0, 0, 0));
            q.push_back(mk(0, 0, 12'h000, 1, 0, 0));
          end
        endcase
      end
    end
  end

  // Called just after a posedge; returns just after the edge that ends cycle 0
  task automatic issue(input cmd_op_e op, input logic [23:0] v);
    int t;
    t = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_value = v;
    do begin
      @(negedge clock);
      t++;
    end while (!bus.cmd_ready && t < 500);
    if (!bus.cmd_ready) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: cmd_ready still 0 after %0d cycles", t);
    end
    @(posedge clock); #1;
    bus.cmd_valid = 1'b0;
  endtask

  bit rnd_done = 1'b0;

  initial begin
    int t;
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = CMD_LOAD;
    bus.cmd_value = '0;
    abort = 1'b0;
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;

    @(negedge clock);
    chk("rst_cmd_ready", bus.cmd_ready, 0);
    chk("rst_inst_en", inst_en, 0);
    chk("rst_inst", inst, 0);
    chk("rst_done_aborted", {done, aborted}, 0);
    @(negedge clock);
    chk("idle_cmd_ready", bus.cmd_ready, 1);

    // LOAD 0x123456
    @(posedge clock); #1;
    issue(CMD_LOAD, 24'h123456);
    @(negedge clock); chk("load_c1", {inst_en, inst}, 13'h1156);
    @(negedge clock); chk("load_c2", {inst_en, inst}, 13'h1234);
    @(negedge clock); chk("load_c3", {inst_en, inst}, 13'h1312);
    @(negedge clock); chk("load_c4_done", {done, inst_en}, 2'b10);
    chk("load_cnt", cnt, 24'h123456);
    @(negedge clock); chk("load_c5_ready", bus.cmd_ready, 1);

    // TIMER 5
    @(posedge clock); #1;
    issue(CMD_TIMER, 24'd5);
    @(negedge clock); chk("t5_c1", {inst_en, inst}, 13'h1105);
    @(negedge clock); chk("t5_c2", {inst_en, inst}, 13'h1200);
    @(negedge clock); chk("t5_c3", {inst_en, inst}, 13'h1300);
    @(negedge clock); chk("t5_c4_ccd", {inst_en, inst}, 13'h1700);
    t = 4;
    do begin
      @(negedge clock);
      t++;
    end while (!swc_ready && t < 100);
    chk("t5_ready_cycle", t, 8);
    @(negedge clock); chk("t5_done", {done, aborted}, 2'b10);
    chk("t5_cnt", cnt, 0);

    // TIMER 0: three loads, no CCD
    @(posedge clock); #1;
    issue(CMD_TIMER, 24'd0);
    repeat (3) begin @(negedge clock); chk("t0_ld_en", inst_en, 1); end
    @(negedge clock); chk("t0_c4_done", {done, inst_en}, 2'b10);
    @(negedge clock); chk("t0_c5_no_ccd", inst_en, 0);
    chk("t0_cnt", cnt, 0);

    // TIMER 0x100 aborted in cycle 10
    @(posedge clock); #1;
    issue(CMD_TIMER, 24'h000100);
    repeat (9) @(posedge clock);
    #1 abort = 1'b1;
    @(posedge clock); #1 abort = 1'b0;
    @(negedge clock); chk("ab_c11_ccs", {inst_en, inst}, 13'h1800);
    @(negedge clock); chk("ab_c12_done", {done, aborted}, 2'b11);
    @(negedge clock); chk("ab_cnt_frozen", cnt, 24'h0000F9);

    // STEP then STOP with cmd_valid held throughout
    @(posedge clock); #1;
    issue(CMD_STEP, 24'd0);
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = CMD_STOP;
    @(negedge clock); chk("ss_c1_cou", {inst_en, inst, bus.cmd_ready}, 14'h2800);
    @(negedge clock); chk("ss_c2_done", {done, bus.cmd_ready}, 2'b10);
    @(negedge clock); chk("ss_c3_ready", bus.cmd_ready, 1);
    @(posedge clock); #1 bus.cmd_valid = 1'b0;
    @(negedge clock); chk("ss_c4_ccs", {inst_en, inst}, 13'h1800);
    @(negedge clock); chk("ss_c5_done", {done, aborted}, 2'b10);

    // reset during Ld1
    @(posedge clock); #1;
    issue(CMD_LOAD, 24'hABCDEF);
    @(posedge clock); #1 reset = 1'b1;
    @(posedge clock); #1 reset = 1'b0;
    @(negedge clock); chk("rs_c3", {inst_en, bus.cmd_ready, done}, 3'b000);
    @(negedge clock); chk("rs_c4", {inst_en, bus.cmd_ready, done}, 3'b010);
    @(negedge clock); chk("rs_c5_no_done", done, 0);

    // randomized traffic
    fork
      begin
        for (int i = 0; i < 60; i++) begin
          int          gap;
          cmd_op_e     op;
          logic [23:0] v;
          gap = $urandom_range(0, 3);
          op  = cmd_op_e'($urandom_range(0, 3));
          if (op == CMD_TIMER)
            v = ($urandom_range(0, 3) == 0) ? 24'd0 : 24'($urandom_range(1, 25));
          else
            v = 24'($urandom);
          repeat (gap) begin @(posedge clock); #1; end
          issue(op, v);
          if ($urandom_range(0, 11) == 0) begin
            repeat ($urandom_range(0, 4)) begin @(posedge clock); #1; end
            reset = 1'b1;
            @(posedge clock); #1 reset = 1'b0;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clock); #1;
          abort = ($urandom_range(0, 15) == 0);
        end
        abort = 1'b0;
      end
    join

    repeat (40) @(posedge clock);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
